// File: rtl/button_event_arbiter_if.sv
// Event handshake bundle between the button front end (master) and its consumer (slave).
// Carries raw button levels in, and the offered event, pending flags and overflow pulse out.
interface button_event_arbiter_if #(
    parameter int N_BTN = 5,
    parameter int ID_W  = 3
);
    logic [N_BTN-1:0] i_BTN;
    logic             o_VALID;
    logic [ID_W-1:0]  o_BTN_ID;
    logic             i_READY;
    logic [N_BTN-1:0] o_PEND;
    logic             o_OVERFLOW;

    modport master (
        input  i_BTN, i_READY,
        output o_VALID, o_BTN_ID, o_PEND, o_OVERFLOW
    );

    modport slave (
        output i_BTN, i_READY,
        input  o_VALID, o_BTN_ID, o_PEND, o_OVERFLOW
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Debounced push-button events, offered one at a time with round-robin priority.
// Stable press -> o_PEND one cycle later -> o_VALID one cycle after that; the offer holds while i_READY is low.
module button_event_arbiter #(
    parameter int N_BTN        = 5,
    parameter int ID_W         = 3,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic                   i_CLK,
    input  logic                   i_RST_N,
    button_event_arbiter_if.master bus
);
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic             ovf_q, ovf_d;
    logic [N_BTN-1:0] accept_mask;
    logic             sel_found;
    logic [ID_W-1:0]  sel_id;

    // A level change is accepted only after it has held for DEBOUNCE_CYC cycles.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Round-robin pick: lowest pending index at or above rr_q, else lowest overall.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int j = 0; j < N_BTN; j++) begin
            if (!sel_found && pend_q[j] && (j >= int'(rr_q))) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(j);
            end
        end
        for (int j = 0; j < N_BTN; j++) begin
            if (!sel_found && pend_q[j]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_d        = rr_q;
        accept_mask = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    id_d    = sel_id;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.i_READY) begin
                    for (int j = 0; j < N_BTN; j++) begin
                        accept_mask[j] = (id_q == ID_W'(j));
                    end
                    rr_d    = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + ID_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new press colliding with its own accept re-arms the flag instead of overflowing.
        pend_d = (pend_q & ~accept_mask) | press_q;
        ovf_d  = |(press_q & pend_q & ~accept_mask);
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            pend_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            state_q  <= S_IDLE;
            id_q     <= '0;
            rr_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= bus.i_BTN;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            pend_q   <= pend_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q  <= state_d;
            id_q     <= id_d;
            rr_q     <= rr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.o_VALID    = (state_q == S_OFFER);
    assign bus.o_BTN_ID   = id_q;
    assign bus.o_PEND     = pend_q;
    assign bus.o_OVERFLOW = ovf_q;
endmodule
